// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: digit indices, per-digit limits
// and the press-pulse bundle passed from the conditioner.
package stopwatch_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t DIGIT_MIN_L = 3'd0;
  localparam digit_idx_t DIGIT_MIN_R = 3'd1;
  localparam digit_idx_t DIGIT_SEC_L = 3'd2;
  localparam digit_idx_t DIGIT_SEC_R = 3'd3;

  localparam logic [3:0] DIGIT_LIMIT [4] = '{4'd9, 4'd9, 4'd5, 4'd9};

  typedef struct packed {
    logic inc;
    logic sel;
    logic rst;
    logic pause;
  } press_t;

  function automatic logic [3:0] digit_limit(input digit_idx_t idx);
    return DIGIT_LIMIT[idx[1:0]];
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer plus a stability counter; stable only
// follows the synced input after DEB_CYCLES unchanged samples.
module debounce #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Stopwatch front end: debounced buttons become press pulses that
// drive pause/clear control and the digit-adjust datapath.
module input_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       sw_adj,
  output logic       paused,
  output logic       clr,
  output logic       adj,
  output logic [2:0] adj_sel,
  output logic [3:0] adj_val,
  output logic       adj_we
);

  logic [4:0] raw;
  logic [4:0] stable;

  assign raw = {sw_adj, btn_inc, btn_sel, btn_reset, btn_pause};

  for (genvar g = 0; g < 5; g++) begin : g_deb
    debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[g]),
      .stable(stable[g])
    );
  end

  logic       btn_prev_q;
  logic [3:0] prev_q;
  press_t     press;
  logic       adj_s;
  logic       adj_edge;

  logic       paused_q, paused_d;
  logic       clr_q, clr_d;
  digit_idx_t sel_q, sel_d;
  logic [3:0] val_q, val_d;
  logic       we_q, we_d;

  // Edge detect on the registered stable levels; releases never pulse.
  assign press    = press_t'(stable[3:0] & ~prev_q);
  assign adj_s    = stable[4];
  assign adj_edge = adj_s ^ btn_prev_q;

  always_comb begin
    paused_d = paused_q;
    clr_d    = press.rst;
    sel_d    = sel_q;
    val_d    = val_q;
    we_d     = 1'b0;
    if (press.pause && !adj_s) begin
      paused_d = ~paused_q;
    end
    // Adjust-mode entry/exit overrides any coincident sel/inc press.
    if (adj_edge) begin
      sel_d = DIGIT_MIN_L;
      val_d = '0;
    end else if (adj_s) begin
      if (press.sel) begin
        sel_d = (sel_q == DIGIT_SEC_R) ? DIGIT_MIN_L : sel_q + 3'd1;
        val_d = '0;
      end else if (press.inc) begin
        val_d = (val_q == digit_limit(sel_q)) ? 4'd0 : val_q + 4'd1;
        we_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      btn_prev_q <= 1'b0;
      paused_q   <= 1'b0;
      clr_q      <= 1'b0;
      sel_q      <= DIGIT_MIN_L;
      val_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      prev_q     <= stable[3:0];
      btn_prev_q <= adj_s;
      paused_q   <= paused_d;
      clr_q      <= clr_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      we_q       <= we_d;
    end
  end

  assign paused  = paused_q;
  assign clr     = clr_q;
  assign adj     = adj_s;
  assign adj_sel = sel_q;
  assign adj_val = val_q;
  assign adj_we  = we_q;

endmodule
